// File: rtl/if_fetch_seq_pkg.sv
// Shared types for the instruction-fetch sequencer: FSM states, in-flight byte tags
// and the byte-lane merge used to assemble little-endian words.
package if_fetch_seq_pkg;

  localparam logic [2:0] FETCH_BYTES = 3'd4;

  typedef enum logic [1:0] {
    ST_ISSUE = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] idx;
  } fetch_tag_t;

  // Lane 0 is bits 7:0, so the byte at the lowest address lands in the low lane.
  function automatic logic [31:0] put_lane(input logic [31:0] word,
                                           input logic [1:0]  idx,
                                           input logic [7:0]  data);
    logic [31:0] w;
    w = word;
    w[{idx, 3'b000} +: 8] = data;
    return w;
  endfunction

endpackage

// File: rtl/if_fetch_seq_if.sv
// Signal bundle between the fetch sequencer, memctrl's IF side and the ID stage.
interface if_fetch_seq_if;
  import if_fetch_seq_pkg::*;

  logic         rdy;
  logic         mem_busy_i;
  logic [7:0]   ram_din_i;
  logic         jump_i;
  logic [31:0]  jump_addr_i;
  logic         stall_i;
  logic         if_request_o;
  logic [31:0]  if_addr_o;
  logic         inst_valid_o;
  logic [31:0]  inst_o;
  logic [31:0]  inst_pc_o;
  fetch_state_t state_dbg;

  // Handshake to ID: an instruction transfers in a cycle with inst_valid_o=1,
  // stall_i=0 and jump_i=0; while stalled inst_o/inst_pc_o hold unchanged.
  modport master (
    input  rdy, mem_busy_i, ram_din_i, jump_i, jump_addr_i, stall_i,
    output if_request_o, if_addr_o, inst_valid_o, inst_o, inst_pc_o, state_dbg
  );

  modport slave (
    output rdy, mem_busy_i, ram_din_i, jump_i, jump_addr_i, stall_i,
    input  if_request_o, if_addr_o, inst_valid_o, inst_o, inst_pc_o, state_dbg
  );

endinterface

// File: rtl/if_fetch_seq_fetch_tag_pipe.sv
// Delay line that follows each issued byte request until its RAM data returns,
// so the receiver knows which lane (if any) the current ram_din_i belongs to.
module if_fetch_seq_fetch_tag_pipe
  import if_fetch_seq_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       enable,
  input  fetch_tag_t push,
  output fetch_tag_t pop
);

  fetch_tag_t stage [DEPTH];

  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else if (enable) begin
      stage[0] <= push;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign pop = stage[DEPTH-1];

endmodule

// File: rtl/if_fetch_seq.sv
// Instruction-fetch sequencer: requests four bytes per instruction from memctrl,
// assembles them little-endian and offers the word plus PC to ID.
module if_fetch_seq
  import if_fetch_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0,
  parameter int          RAM_LATENCY = 1
) (
  input logic            clk,
  input logic            rst,
  if_fetch_seq_if.master bus
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  asm_word;
  logic [31:0]  inst;
  logic [31:0]  inst_pc;
  logic         inst_valid;
  logic [2:0]   issue_cnt;
  logic [2:0]   recv_cnt;
  logic [2:0]   recv_next;
  logic [31:0]  word_next;
  logic         req;
  logic         rx;
  fetch_tag_t   push;
  fetch_tag_t   pop;

  always_comb begin
    req       = bus.rdy & ~rst & ~bus.jump_i & (state == ST_ISSUE) & ~bus.mem_busy_i;
    push      = '0;
    push.valid = req;
    push.idx  = issue_cnt[1:0];
    rx        = pop.valid;
    word_next = rx ? put_lane(asm_word, pop.idx, bus.ram_din_i) : asm_word;
    recv_next = recv_cnt + {2'b00, rx};
  end

  // A jump flushes in-flight tags so their bytes are dropped when they return.
  if_fetch_seq_fetch_tag_pipe #(.DEPTH(RAM_LATENCY)) u_tag_pipe (
    .clk    (clk),
    .clear  (rst | (bus.rdy & bus.jump_i)),
    .enable (bus.rdy),
    .push   (push),
    .pop    (pop)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_ISSUE;
      pc         <= RESET_PC;
      issue_cnt  <= '0;
      recv_cnt   <= '0;
      asm_word   <= '0;
      inst_valid <= 1'b0;
      inst       <= '0;
      inst_pc    <= '0;
    end else if (bus.rdy) begin
      if (bus.jump_i) begin
        state      <= ST_ISSUE;
        pc         <= bus.jump_addr_i;
        issue_cnt  <= '0;
        recv_cnt   <= '0;
        inst_valid <= 1'b0;
      end else begin
        case (state)
          ST_ISSUE, ST_DRAIN: begin
            if (req) begin
              issue_cnt <= issue_cnt + 3'd1;
              if (issue_cnt == FETCH_BYTES - 3'd1) state <= ST_DRAIN;
            end
            if (rx) begin
              asm_word <= word_next;
              recv_cnt <= recv_next;
              if (recv_next == FETCH_BYTES) begin
                inst_valid <= 1'b1;
                inst       <= word_next;
                inst_pc    <= pc;
                state      <= ST_HOLD;
              end
            end
          end
          ST_HOLD: begin
            if (!bus.stall_i) begin
              inst_valid <= 1'b0;
              pc         <= pc + 32'd4;
              issue_cnt  <= '0;
              recv_cnt   <= '0;
              state      <= ST_ISSUE;
            end
          end
          default: state <= ST_ISSUE;
        endcase
      end
    end
  end

  assign bus.if_request_o = req;
  assign bus.if_addr_o    = req ? (pc + {29'b0, issue_cnt}) : 32'h0;
  assign bus.inst_valid_o = inst_valid;
  assign bus.inst_o       = inst;
  assign bus.inst_pc_o    = inst_pc;
  assign bus.state_dbg    = state;

endmodule

// File: tb/tb_if_fetch_seq.sv
// Directed bench for if_fetch_seq: one instance with RAM_LATENCY=1 and one with
// RAM_LATENCY=2, each fed by a byte RAM model with matching read latency.
module tb_if_fetch_seq;
  import if_fetch_seq_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic rst2;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  if_fetch_seq_if bus ();
  if_fetch_seq_if bus2 ();

  if_fetch_seq #(.RESET_PC(32'h0), .RAM_LATENCY(1)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  if_fetch_seq #(.RESET_PC(32'h0), .RAM_LATENCY(2)) u_dut2 (
    .clk (clk),
    .rst (rst2),
    .bus (bus2)
  );

  // Byte RAM: data for a request appears RAM_LATENCY cycles later, frozen while rdy=0.
  // Slots without an IF request return 8'hEE, standing in for MEM-side traffic.
  logic [7:0] mem [512];
  logic [7:0] ram1_q = 8'hEE;
  logic [7:0] ram2_q [2] = '{8'hEE, 8'hEE};

  always @(posedge clk) begin
    if (bus.rdy) ram1_q <= bus.if_request_o ? mem[bus.if_addr_o[8:0]] : 8'hEE;
  end

  always @(posedge clk) begin
    if (bus2.rdy) begin
      ram2_q[0] <= bus2.if_request_o ? mem[bus2.if_addr_o[8:0]] : 8'hEE;
      ram2_q[1] <= ram2_q[0];
    end
  end

  assign bus.ram_din_i  = ram1_q;
  assign bus2.ram_din_i = ram2_q[1];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[0]     = 8'h13; mem[1]     = 8'h05; mem[2]     = 8'h10; mem[3]     = 8'h00;
    mem[4]     = 8'h93; mem[5]     = 8'h05; mem[6]     = 8'h10; mem[7]     = 8'h00;
    mem[8]     = 8'h33; mem[9]     = 8'h05; mem[10]    = 8'hb5; mem[11]    = 8'h00;
    mem[9'h100] = 8'hb7; mem[9'h101] = 8'h02; mem[9'h102] = 8'h00; mem[9'h103] = 8'h00;
    mem[9'h104] = 8'h13; mem[9'h105] = 8'h01; mem[9'h106] = 8'h01; mem[9'h107] = 8'hff;

    rst = 1'b1; rst2 = 1'b1;
    bus.rdy = 1'b1;  bus.mem_busy_i = 1'b0;  bus.jump_i = 1'b0;  bus.jump_addr_i = 32'h0;  bus.stall_i = 1'b0;
    bus2.rdy = 1'b1; bus2.mem_busy_i = 1'b0; bus2.jump_i = 1'b0; bus2.jump_addr_i = 32'h0; bus2.stall_i = 1'b0;

    // Reset state
    repeat (2) step();
    chk("rst_valid", bus.inst_valid_o, 32'h0);
    chk("rst_inst", bus.inst_o, 32'h0);
    chk("rst_pc", bus.inst_pc_o, 32'h0);
    chk("rst_req", bus.if_request_o, 32'h0);
    chk("rst_addr", bus.if_addr_o, 32'h0);
    chk("rst_state", 32'(bus.state_dbg), 32'(ST_ISSUE));

    // First fetch from RESET_PC
    step(); rst = 1'b0; #1;
    chk("f0_req0", bus.if_request_o, 32'h1);
    chk("f0_addr0", bus.if_addr_o, 32'h0);
    for (int i = 1; i < 4; i++) begin
      step();
      chk("f0_addr", bus.if_addr_o, 32'(i));
    end
    step();
    chk("f0_drain_req", bus.if_request_o, 32'h0);
    chk("f0_drain_state", 32'(bus.state_dbg), 32'(ST_DRAIN));
    chk("f0_drain_valid", bus.inst_valid_o, 32'h0);

    // Valid at t0+5; stall three cycles in HOLD
    step(); bus.stall_i = 1'b1; #1;
    chk("f0_valid", bus.inst_valid_o, 32'h1);
    chk("f0_inst", bus.inst_o, 32'h00100513);
    chk("f0_pc", bus.inst_pc_o, 32'h0);
    chk("f0_hold_state", 32'(bus.state_dbg), 32'(ST_HOLD));
    for (int i = 0; i < 2; i++) begin
      step();
      chk("stall_valid", bus.inst_valid_o, 32'h1);
      chk("stall_inst", bus.inst_o, 32'h00100513);
      chk("stall_req", bus.if_request_o, 32'h0);
    end
    step(); bus.stall_i = 1'b0; #1;
    chk("stall_rel_valid", bus.inst_valid_o, 32'h1);

    // Next instruction at pc 4
    step();
    chk("f1_valid_clr", bus.inst_valid_o, 32'h0);
    chk("f1_addr4", bus.if_addr_o, 32'h4);
    for (int i = 5; i < 8; i++) begin
      step();
      chk("f1_addr", bus.if_addr_o, 32'(i));
    end
    step();
    step();
    chk("f1_valid", bus.inst_valid_o, 32'h1);
    chk("f1_inst", bus.inst_o, 32'h00100593);
    chk("f1_pc", bus.inst_pc_o, 32'h4);

    // MEM owns the port during t0+1..t0+2
    step();
    chk("busy_addr8", bus.if_addr_o, 32'h8);
    step(); bus.mem_busy_i = 1'b1; #1;
    chk("busy_req_a", bus.if_request_o, 32'h0);
    chk("busy_addr_a", bus.if_addr_o, 32'h0);
    step();
    chk("busy_req_b", bus.if_request_o, 32'h0);
    step(); bus.mem_busy_i = 1'b0; #1;
    chk("busy_resume", bus.if_addr_o, 32'h9);
    step(); chk("busy_addr_a2", bus.if_addr_o, 32'ha);
    step(); chk("busy_addr_b2", bus.if_addr_o, 32'hb);
    step(); chk("busy_early", bus.inst_valid_o, 32'h0);
    step();
    chk("busy_valid", bus.inst_valid_o, 32'h1);
    chk("busy_inst", bus.inst_o, 32'h00b50533);
    chk("busy_pc", bus.inst_pc_o, 32'h8);

    // Jump to 0x100 while byte 2 of pc 12 is in flight
    step(); chk("j_addr12", bus.if_addr_o, 32'hc);
    step(); chk("j_addr13", bus.if_addr_o, 32'hd);
    step(); chk("j_addr14", bus.if_addr_o, 32'he);
    step(); bus.jump_i = 1'b1; bus.jump_addr_i = 32'h100; #1;
    chk("j_req_blk", bus.if_request_o, 32'h0);
    step(); bus.jump_i = 1'b0; #1;
    chk("j_addr100", bus.if_addr_o, 32'h100);
    chk("j_valid0", bus.inst_valid_o, 32'h0);
    for (int i = 1; i < 4; i++) begin
      step();
      chk("j_addr", bus.if_addr_o, 32'h100 + 32'(i));
    end
    step(); chk("j_early", bus.inst_valid_o, 32'h0);
    step();
    chk("j_valid", bus.inst_valid_o, 32'h1);
    chk("j_inst", bus.inst_o, 32'h000002b7);
    chk("j_pc", bus.inst_pc_o, 32'h100);

    // rdy low for two cycles mid-ISSUE
    step(); chk("rdy_addr104", bus.if_addr_o, 32'h104);
    step(); chk("rdy_addr105", bus.if_addr_o, 32'h105);
    step(); bus.rdy = 1'b0; #1;
    chk("rdy_req_a", bus.if_request_o, 32'h0);
    chk("rdy_addr_a", bus.if_addr_o, 32'h0);
    step();
    chk("rdy_req_b", bus.if_request_o, 32'h0);
    step(); bus.rdy = 1'b1; #1;
    chk("rdy_resume", bus.if_addr_o, 32'h106);
    step(); chk("rdy_addr107", bus.if_addr_o, 32'h107);
    step(); chk("rdy_early", bus.inst_valid_o, 32'h0);
    step();
    chk("rdy_valid", bus.inst_valid_o, 32'h1);
    chk("rdy_inst", bus.inst_o, 32'hff010113);
    chk("rdy_pc", bus.inst_pc_o, 32'h104);

    // Reset in the middle of DRAIN
    for (int i = 0; i < 4; i++) begin
      step();
      chk("r_addr", bus.if_addr_o, 32'h108 + 32'(i));
    end
    step(); rst = 1'b1; #1;
    chk("r_drain_state", 32'(bus.state_dbg), 32'(ST_DRAIN));
    step();
    chk("r_valid", bus.inst_valid_o, 32'h0);
    chk("r_inst", bus.inst_o, 32'h0);
    chk("r_pc", bus.inst_pc_o, 32'h0);
    chk("r_req", bus.if_request_o, 32'h0);
    chk("r_addr0", bus.if_addr_o, 32'h0);
    step(); rst = 1'b0; #1;
    chk("r_restart", bus.if_request_o, 32'h1);
    chk("r_restart_addr", bus.if_addr_o, 32'h0);
    repeat (4) step();
    chk("r_early", bus.inst_valid_o, 32'h0);
    step();
    chk("r_valid2", bus.inst_valid_o, 32'h1);
    chk("r_inst2", bus.inst_o, 32'h00100513);
    chk("r_pc2", bus.inst_pc_o, 32'h0);

    // RAM_LATENCY = 2 instance
    step(); rst2 = 1'b0; #1;
    chk("l2_addr0", bus2.if_addr_o, 32'h0);
    for (int i = 1; i < 4; i++) begin
      step();
      chk("l2_addr", bus2.if_addr_o, 32'(i));
    end
    step(); chk("l2_drain", 32'(bus2.state_dbg), 32'(ST_DRAIN));
    step(); chk("l2_early", bus2.inst_valid_o, 32'h0);
    step();
    chk("l2_valid", bus2.inst_valid_o, 32'h1);
    chk("l2_inst", bus2.inst_o, 32'h00100513);
    chk("l2_pc", bus2.inst_pc_o, 32'h0);
    step(); chk("l2_addr4", bus2.if_addr_o, 32'h4);
    step(); chk("l2_addr5", bus2.if_addr_o, 32'h5);
    step(); bus2.jump_i = 1'b1; bus2.jump_addr_i = 32'h100; #1;
    chk("l2_j_req", bus2.if_request_o, 32'h0);
    step(); bus2.jump_i = 1'b0; #1;
    chk("l2_j_addr100", bus2.if_addr_o, 32'h100);
    for (int i = 1; i < 4; i++) begin
      step();
      chk("l2_j_addr", bus2.if_addr_o, 32'h100 + 32'(i));
    end
    step(); chk("l2_j_early_a", bus2.inst_valid_o, 32'h0);
    step(); chk("l2_j_early_b", bus2.inst_valid_o, 32'h0);
    step();
    chk("l2_j_valid", bus2.inst_valid_o, 32'h1);
    chk("l2_j_inst", bus2.inst_o, 32'h000002b7);
    chk("l2_j_pc", bus2.inst_pc_o, 32'h100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
